push_rpu: RTL and testbench
===========================

Name: push_rpu

Overview:
- Push-path processing unit for one level of the 4-ary SRAM-backed PIFO tree; companion to the pop RPU on the same node SRAM row format.
- Accepts a push from the parent level and reads the addressed 4-slot node.
- Places the element in the least-populated sub-tree, keeping the smaller priority in the slot and forwarding the other element to the child level.
- Writes the updated row back in the following cycle.

Parameters:
- PTW, 16, payload width; the priority is the low PTW bits of an element.
- MTW, 0, metadata width carried above the payload.
- CTW, 10, sub-tree element counter width.
- ADW, 20, node address width.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous active-high reset.
- o_fsm  out  2  current state.
- i_push  in  1  push command from parent; honoured only when o_ready=1.
- i_push_data  in  MTW+PTW  element pushed by parent.
- o_ready  out  1  high when fsm is not ST_PUSH.
- o_push  out  1  push command to child level.
- o_push_data  out  MTW+PTW  element forwarded to child.
- o_child_addr  out  ADW  child node address, 4*node_addr+k.
- i_my_addr  in  ADW  node address; valid with i_push.
- i_is_leaf  in  1  node is at the last level; forwarding to a child is illegal.
- o_read  out  1  SRAM read strobe.
- o_read_addr  out  ADW  equals i_my_addr, combinational.
- i_read_data  in  4*(CTW+MTW+PTW)  row read; valid one cycle after o_read.
- o_write  out  1  SRAM write strobe.
- o_write_addr  out  ADW  latched node address.
- o_write_data  out  4*(CTW+MTW+PTW)  updated row.
- o_overflow  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Row format:
  - W = CTW+MTW+PTW.
  - Slot k occupies bits [(k+1)*W-1 : k*W] as {size[CTW], elem[MTW+PTW]}.
  - size counts elements in the slot plus its sub-tree.
  - size==0 means the slot is empty; its elem field is don't-care.
- States: ST_IDLE=2'b00, ST_PUSH=2'b11, ST_WB=2'b10.
  - ST_IDLE / ST_WB: if i_push, latch i_my_addr→addr_q and i_push_data→data_q, go to ST_PUSH; else go to ST_IDLE and clear addr_q.
  - ST_PUSH: always go to ST_WB.
- o_read = i_push & (fsm==ST_IDLE | fsm==ST_WB). A push arriving in ST_PUSH is ignored, and the bench flags it as a protocol error.
- ST_PUSH computation, combinational from i_read_data:
  - Target slot k = index of minimum size. Ties go to the lowest index.
  - Case A, size_k==0: elem_k=data_q, size_k=1. o_push=0.
  - Case B, size_k!=0 and not leaf:
    - size_k increments by 1.
    - If data_q[PTW-1:0] < elem_k[PTW-1:0]: elem_k=data_q and o_push_data=old elem_k.
    - Otherwise, including equality (FIFO among equal priorities): elem_k is unchanged and o_push_data=data_q.
    - o_push=1; o_child_addr=4*addr_q+k, truncated to ADW.
  - Drop case: size_k==all-ones, or (i_is_leaf and size_k!=0).
    - Element dropped: o_write=0, o_push=0, o_overflow=1 for that cycle.
  - Other slots pass through unchanged.
  - In cases A and B, o_write=1 with o_write_addr=addr_q.
- Outputs outside ST_PUSH: o_write=0, o_write_data=0, o_push=0, o_overflow=0, o_push_data all-ones, o_child_addr all-ones.
- Latency: push accepted at edge N → write and child push at cycle N+1. Sustained rate is one push per 2 cycles (accept in ST_WB).
- ST_WB has no outputs. It is the read-after-write gap, so a back-to-back push to the same node sees the written row.
- Reset:
  - i_rst forces fsm=ST_IDLE and addr_q=data_q=0 at the next edge.
  - o_write, o_push and o_overflow are gated by !i_rst, so no partial update is issued in a cycle where reset is high.
  - All outputs hold idle values while reset is held.

Decomposition:
- Package pifo_sram_pkg:
  - State encodings ST_IDLE, ST_PUSH, ST_WB.
  - Function giving the slot width W from CTW/MTW/PTW.
  - Slot field offset helpers.
  - EMPTY_ELEM constant (all-ones).
- Sub-module push_rpu_slot_sel: combinational 4-way min-size selector with lowest-index tie-break. Outputs k, size_k and elem_k.
- The FSM and the row rebuild stay in push_rpu.

Test Plan:
- Empty row (all sizes 0), push 0x0040 to addr 3 → o_write at next cycle, addr 3, slot0={1,0x0040}, o_push=0, then ST_WB.
- Sizes {0:2,1:1,2:1,3:1}, slot1 elem 0x0100, push 0x0020 → k=1, slot1={2,0x0020}, o_push=1, o_push_data=0x0100, o_child_addr=4*addr+1.
- Sizes all 1, elems 0x10/0x20/0x30/0x40, push 0x0010 → k=0, slot0 unchanged except size=2, o_push_data=0x0010 (equal priority goes down).
- i_is_leaf=1, sizes all 1, push 0x0005 → o_overflow=1 for one cycle, o_write=0, o_push=0.
- Back-to-back pushes to the same address, second asserted in ST_WB → o_read in ST_WB, second write reflects the first write; no missed push.
- Assert i_rst during ST_PUSH → o_write=0 and o_push=0 that cycle, fsm=ST_IDLE next cycle, o_child_addr all-ones.

Source files
------------

// File: rtl/pifo_sram_pkg.sv
// Shared definitions for the SRAM-backed 4-ary PIFO tree: FSM encodings
// and the layout of a node row.
package pifo_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WB   = 2'b10,
        ST_PUSH = 2'b11
    } fsm_e;

    localparam int NSLOT = 4;

    // Sentinel for "no element"; callers slice the low payload bits they need.
    localparam logic [63:0] EMPTY_ELEM = '1;

    function automatic int slot_width(input int ctw, input int mtw, input int ptw);
        return ctw + mtw + ptw;
    endfunction

    function automatic int slot_elem_lsb(input int k, input int w);
        return k * w;
    endfunction

    function automatic int slot_size_lsb(input int k, input int w, input int ew);
        return k * w + ew;
    endfunction

endpackage

// File: rtl/push_rpu_slot_sel.sv
// Combinational 4-way minimum-size slot selector; ties resolve to the lowest index.
module push_rpu_slot_sel
    import pifo_sram_pkg::*;
#(
    parameter int CTW = 10,
    parameter int EW  = 16
) (
    input  logic [NSLOT*(CTW+EW)-1:0] row,
    output logic [1:0]                k,
    output logic [CTW-1:0]            size_k,
    output logic [EW-1:0]             elem_k
);

    localparam int W = CTW + EW;

    logic [CTW-1:0] size_arr [NSLOT];
    logic [EW-1:0]  elem_arr [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_unpack
            assign size_arr[gi] = row[slot_size_lsb(gi, W, EW) +: CTW];
            assign elem_arr[gi] = row[slot_elem_lsb(gi, W) +: EW];
        end
    endgenerate

    logic           lo_pick;
    logic           hi_pick;
    logic           top_pick;
    logic [CTW-1:0] lo_size;
    logic [CTW-1:0] hi_size;

    // Strict compares everywhere so equal sizes keep the lower index.
    assign lo_pick  = size_arr[1] < size_arr[0];
    assign hi_pick  = size_arr[3] < size_arr[2];
    assign lo_size  = lo_pick ? size_arr[1] : size_arr[0];
    assign hi_size  = hi_pick ? size_arr[3] : size_arr[2];
    assign top_pick = hi_size < lo_size;

    assign k      = top_pick ? {1'b1, hi_pick} : {1'b0, lo_pick};
    assign size_k = size_arr[k];
    assign elem_k = elem_arr[k];

endmodule

// File: rtl/push_rpu.sv
// Push-path RPU for one PIFO tree level: read node row, place element in the
// least-populated sub-tree, forward the loser to the child, write the row back.
module push_rpu
    import pifo_sram_pkg::*;
#(
    parameter int PTW = 16,
    parameter int MTW = 0,
    parameter int CTW = 10,
    parameter int ADW = 20
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    output logic [1:0]                              o_fsm,
    input  logic                                    i_push,
    input  logic [MTW+PTW-1:0]                      i_push_data,
    output logic                                    o_ready,
    output logic                                    o_push,
    output logic [MTW+PTW-1:0]                      o_push_data,
    output logic [ADW-1:0]                          o_child_addr,
    input  logic [ADW-1:0]                          i_my_addr,
    input  logic                                    i_is_leaf,
    output logic                                    o_read,
    output logic [ADW-1:0]                          o_read_addr,
    input  logic [NSLOT*(CTW+MTW+PTW)-1:0]          i_read_data,
    output logic                                    o_write,
    output logic [ADW-1:0]                          o_write_addr,
    output logic [NSLOT*(CTW+MTW+PTW)-1:0]          o_write_data,
    output logic                                    o_overflow
);

    localparam int EW = MTW + PTW;
    localparam int W  = slot_width(CTW, MTW, PTW);
    localparam int RW = NSLOT * W;

    fsm_e           fsm_reg,  fsm_next;
    logic [ADW-1:0] addr_reg, addr_next;
    logic [EW-1:0]  data_reg, data_next;

    always_comb begin
        fsm_next  = fsm_reg;
        addr_next = addr_reg;
        data_next = data_reg;
        case (fsm_reg)
            ST_PUSH: fsm_next = ST_WB;
            default: begin
                if (i_push) begin
                    fsm_next  = ST_PUSH;
                    addr_next = i_my_addr;
                    data_next = i_push_data;
                end else begin
                    fsm_next  = ST_IDLE;
                    addr_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_reg  <= ST_IDLE;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            fsm_reg  <= fsm_next;
            addr_reg <= addr_next;
            data_reg <= data_next;
        end
    end

    assign o_fsm        = fsm_reg;
    assign o_ready      = (fsm_reg != ST_PUSH);
    assign o_read       = i_push && (fsm_reg != ST_PUSH) && !i_rst;
    assign o_read_addr  = i_my_addr;
    assign o_write_addr = addr_reg;

    logic [1:0]     sel_k;
    logic [CTW-1:0] size_k;
    logic [EW-1:0]  elem_k;

    push_rpu_slot_sel #(
        .CTW (CTW),
        .EW  (EW)
    ) u_slot_sel (
        .row    (i_read_data),
        .k      (sel_k),
        .size_k (size_k),
        .elem_k (elem_k)
    );

    logic           slot_empty;
    logic           drop;
    logic           new_wins;
    logic [CTW-1:0] size_new;
    logic [EW-1:0]  elem_new;
    logic [EW-1:0]  fwd_elem;
    logic [ADW-1:0] child_addr;
    logic [RW-1:0]  row_upd;

    // Equal priorities lose the slot so earlier arrivals stay ahead (FIFO).
    assign slot_empty = (size_k == '0);
    assign drop       = (&size_k) || (i_is_leaf && !slot_empty);
    assign new_wins   = data_reg[PTW-1:0] < elem_k[PTW-1:0];
    assign size_new   = slot_empty ? CTW'(1) : size_k + CTW'(1);
    assign elem_new   = (slot_empty || new_wins) ? data_reg : elem_k;
    assign fwd_elem   = new_wins ? elem_k : data_reg;
    assign child_addr = ADW'({addr_reg, sel_k});

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_row
            assign row_upd[gi*W +: W] = (sel_k == 2'(gi)) ? {size_new, elem_new}
                                                          : i_read_data[gi*W +: W];
        end
    endgenerate

    logic active;
    assign active = (fsm_reg == ST_PUSH) && !i_rst;

    always_comb begin
        o_write      = 1'b0;
        o_write_data = '0;
        o_push       = 1'b0;
        o_overflow   = 1'b0;
        o_push_data  = EMPTY_ELEM[EW-1:0];
        o_child_addr = '1;
        if (active) begin
            if (drop) begin
                o_overflow = 1'b1;
            end else begin
                o_write      = 1'b1;
                o_write_data = row_upd;
                if (!slot_empty) begin
                    o_push       = 1'b1;
                    o_push_data  = fwd_elem;
                    o_child_addr = child_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_push_rpu.sv
// Scoreboard bench for push_rpu: SRAM model, directed corner cases, random pushes.
module tb_push_rpu;

    localparam int PTW = 16;
    localparam int MTW = 0;
    localparam int CTW = 10;
    localparam int ADW = 20;
    localparam int EW  = MTW + PTW;
    localparam int W   = CTW + EW;
    localparam int RW  = 4 * W;

    logic            i_clk;
    logic            i_rst;
    logic [1:0]      o_fsm;
    logic            i_push;
    logic [EW-1:0]   i_push_data;
    logic            o_ready;
    logic            o_push;
    logic [EW-1:0]   o_push_data;
    logic [ADW-1:0]  o_child_addr;
    logic [ADW-1:0]  i_my_addr;
    logic            i_is_leaf;
    logic            o_read;
    logic [ADW-1:0]  o_read_addr;
    logic [RW-1:0]   i_read_data;
    logic            o_write;
    logic [ADW-1:0]  o_write_addr;
    logic [RW-1:0]   o_write_data;
    logic            o_overflow;

    push_rpu #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_fsm        (o_fsm),
        .i_push       (i_push),
        .i_push_data  (i_push_data),
        .o_ready      (o_ready),
        .o_push       (o_push),
        .o_push_data  (o_push_data),
        .o_child_addr (o_child_addr),
        .i_my_addr    (i_my_addr),
        .i_is_leaf    (i_is_leaf),
        .o_read       (o_read),
        .o_read_addr  (o_read_addr),
        .i_read_data  (i_read_data),
        .o_write      (o_write),
        .o_write_addr (o_write_addr),
        .o_write_data (o_write_data),
        .o_overflow   (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Node SRAM seen by the DUT (1-cycle registered read).
    logic [RW-1:0] sram [logic [ADW-1:0]];
    always @(posedge i_clk) begin
        if (o_write) sram[o_write_addr] = o_write_data;
        if (o_read)  i_read_data = sram.exists(o_read_addr) ? sram[o_read_addr] : '0;
    end

    // Reference model: its own copy of every node, updated by the placement rules.
    logic [RW-1:0] model_mem [logic [ADW-1:0]];

    typedef struct {
        logic          wr;
        logic          ov;
        logic          ps;
        logic [ADW-1:0] wa;
        logic [RW-1:0]  wd;
        logic [EW-1:0]  pd;
        logic [ADW-1:0] ca;
    } exp_t;

    exp_t sb [$];

    function automatic exp_t model_push(input logic [ADW-1:0] a, input logic [EW-1:0] d,
                                        input logic leaf);
        exp_t        e;
        logic [RW-1:0] row;
        int unsigned sz [4];
        logic [EW-1:0] el [4];
        int          k;
        row = model_mem.exists(a) ? model_mem[a] : '0;
        for (int i = 0; i < 4; i++) begin
            sz[i] = int'(row[i*W+EW +: CTW]);
            el[i] = row[i*W +: EW];
        end
        k = 0;
        for (int i = 1; i < 4; i++) if (sz[i] < sz[k]) k = i;
        e.wr = 0; e.ov = 0; e.ps = 0; e.wa = '0; e.wd = '0; e.pd = '0; e.ca = '0;
        if (sz[k] == (1 << CTW) - 1 || (leaf && sz[k] != 0)) begin
            e.ov = 1;
        end else begin
            e.wr = 1;
            e.wa = a;
            if (sz[k] == 0) begin
                sz[k] = 1;
                el[k] = d;
            end else begin
                e.ps = 1;
                if (d < el[k]) begin
                    e.pd  = el[k];
                    el[k] = d;
                end else begin
                    e.pd = d;
                end
                sz[k] = sz[k] + 1;
                e.ca = ADW'(a * 4 + k);
            end
            for (int i = 0; i < 4; i++) begin
                row[i*W +: EW]     = el[i];
                row[i*W+EW +: CTW] = CTW'(sz[i]);
            end
            e.wd = row;
            model_mem[a] = row;
        end
        return e;
    endfunction

    task automatic preload(input logic [ADW-1:0] a,
                           input int s0, input int s1, input int s2, input int s3,
                           input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                           input logic [EW-1:0] e2, input logic [EW-1:0] e3);
        logic [RW-1:0] r;
        r = {CTW'(s3), e3, CTW'(s2), e2, CTW'(s1), e1, CTW'(s0), e0};
        sram[a]      = r;
        model_mem[a] = r;
    endtask

    // Called just after a rising edge with the DUT able to accept; returns one
    // cycle later, i.e. inside the ST_PUSH cycle of this push.
    task automatic do_push(input logic [ADW-1:0] a, input logic [EW-1:0] d,
                           input logic leaf, input bit expect_it);
        chk("ready_before_push", {127'b0, o_ready}, 128'd1);
        i_push      = 1'b1;
        i_my_addr   = a;
        i_push_data = d;
        i_is_leaf   = leaf;
        if (expect_it) sb.push_back(model_push(a, d, leaf));
        #1;
        chk("read_strobe", {127'b0, o_read}, 128'd1);
        chk("read_addr", {108'b0, o_read_addr}, {108'b0, a});
        @(posedge i_clk); #1;
        i_push = 1'b0;
    endtask

    // Monitor: every write/overflow/push cycle is one transaction.
    always @(negedge i_clk) begin
        if (!i_rst && (o_write || o_overflow || o_push)) begin
            n_txn++;
            if (sb.size() == 0) begin
                chk("unexpected_txn", {125'b0, o_write, o_overflow, o_push}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fsm_in_push", {126'b0, o_fsm}, 128'd3);
                chk("flags", {125'b0, o_write, o_overflow, o_push}, {125'b0, e.wr, e.ov, e.ps});
                chk("write_addr", {108'b0, o_write ? o_write_addr : 20'd0}, {108'b0, e.wa});
                chk("write_data", {24'b0, o_write ? o_write_data : 104'd0}, {24'b0, e.wd});
                chk("push_data", {112'b0, o_push ? o_push_data : 16'd0}, {112'b0, e.pd});
                chk("child_addr", {108'b0, o_push ? o_child_addr : 20'd0}, {108'b0, e.ca});
                $display("[TB] txn %0d addr=%0h wr=%0b ov=%0b push=%0b pd=%0h child=%0h",
                         n_txn, o_write_addr, o_write, o_overflow, o_push, o_push_data, o_child_addr);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_push = 1'b0; i_push_data = '0; i_my_addr = '0;
        i_is_leaf = 1'b0; i_read_data = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_fsm", {126'b0, o_fsm}, 128'd0);
        chk("rst_ready", {127'b0, o_ready}, 128'd1);
        chk("rst_flags", {125'b0, o_write, o_push, o_overflow}, 128'd0);
        chk("rst_child_addr", {108'b0, o_child_addr}, {108'b0, 20'hFFFFF});
        chk("rst_push_data", {112'b0, o_push_data}, {112'b0, 16'hFFFF});
        chk("rst_write_data", {24'b0, o_write_data}, 128'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Empty row: element lands in slot 0, nothing forwarded, then ST_WB.
        do_push(20'd3, 16'h0040, 1'b0, 1);
        @(posedge i_clk); #1;
        chk("wb_after_push", {126'b0, o_fsm}, 128'd2);
        @(posedge i_clk); #1;

        // Smaller priority displaces slot 1's element toward the child.
        preload(20'd5, 2, 1, 1, 1, 16'h0005, 16'h0100, 16'h0200, 16'h0300);
        do_push(20'd5, 16'h0020, 1'b0, 1);
        @(posedge i_clk); #1; @(posedge i_clk); #1;

        // Equal priority is forwarded, slot keeps its element.
        preload(20'd6, 1, 1, 1, 1, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        do_push(20'd6, 16'h0010, 1'b0, 1);
        @(posedge i_clk); #1; @(posedge i_clk); #1;

        // Leaf with no empty slot: dropped.
        preload(20'd7, 1, 1, 1, 1, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        do_push(20'd7, 16'h0005, 1'b1, 1);
        @(posedge i_clk); #1; @(posedge i_clk); #1;

        // Saturated sub-tree counters: dropped.
        preload(20'd9, 1023, 1023, 1023, 1023, 16'h1, 16'h2, 16'h3, 16'h4);
        do_push(20'd9, 16'h0000, 1'b0, 1);
        @(posedge i_clk); #1; @(posedge i_clk); #1;

        // Child address wraps at ADW bits.
        preload(20'hFFFFF, 3, 3, 3, 2, 16'h0010, 16'h0020, 16'h0030, 16'h0080);
        do_push(20'hFFFFF, 16'h0070, 1'b0, 1);
        @(posedge i_clk); #1; @(posedge i_clk); #1;

        // Back-to-back pushes to one node, each accepted in ST_WB.
        for (int i = 0; i < 6; i++) begin
            do_push(20'd8, 16'(16'h0100 - i * 16), 1'b0, 1);
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;

        // Reset during ST_PUSH suppresses the update.
        preload(20'd10, 1, 1, 1, 1, 16'h0050, 16'h0060, 16'h0070, 16'h0080);
        do_push(20'd10, 16'h0001, 1'b0, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_in_push_write", {127'b0, o_write}, 128'd0);
        chk("rst_in_push_push", {127'b0, o_push}, 128'd0);
        chk("rst_in_push_ovf", {127'b0, o_overflow}, 128'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_fsm_idle", {126'b0, o_fsm}, 128'd0);
        chk("rst_child_ones", {108'b0, o_child_addr}, {108'b0, 20'hFFFFF});
        @(posedge i_clk); #1;
        // Node 10 must be untouched: this push sees the preloaded row.
        do_push(20'd10, 16'h0065, 1'b0, 1);
        @(posedge i_clk); #1;

        // Random traffic over a few nodes to exercise collisions and ties.
        for (int n = 0; n < 80; n++) begin
            int gap;
            do_push(ADW'($urandom_range(0, 3)), 16'($urandom_range(0, 63)),
                    ($urandom_range(0, 9) == 0), 1);
            @(posedge i_clk); #1;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge i_clk); #1; end
        end

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge i_clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
